// File: rtl/cpu_pkg.sv
// Shared CPU constants and state encodings for the fetch / control stages.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_STEP = 2;
  localparam int unsigned PC_SKIP = 4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_ERR   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: branch target (halfword aligned) > skip (+4) > step (+2).
module pc_next_mux #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              branch_en_i,
  input  logic              en_pc_2_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] next_pc_o
);
  import cpu_pkg::*;

  // Priority select; additions wrap modulo 2^ADDR_W.
  always_comb begin
    next_pc_o = pc_i + ADDR_W'(PC_STEP);
    if (branch_en_i) begin
      next_pc_o = {branch_target_i[ADDR_W-1:1], 1'b0};
    end else if (en_pc_2_i) begin
      next_pc_o = pc_i + ADDR_W'(PC_SKIP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake, holds it until pc_inc, and faults on a memory timeout.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_inc,
  input  logic               en_pc_2,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               inst_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err,
  output logic [1:0]         fetch_state
);
  import cpu_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [ADDR_W-1:0]  next_pc;
  logic               timeout_hit;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .pc_i            (pc_q),
    .branch_en_i     (branch_en),
    .en_pc_2_i       (en_pc_2),
    .branch_target_i (branch_target),
    .next_pc_o       (next_pc)
  );

  // Current cycle is the last ack-less FETCH cycle allowed.
  assign timeout_hit = (tmo_q == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack on the timeout cycle takes precedence over the fault.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE:  state_d = FS_FETCH;
      FS_FETCH: begin
        if (mem_ack) begin
          state_d = FS_HOLD;
        end else if (timeout_hit) begin
          state_d = FS_ERR;
        end
      end
      FS_HOLD:  if (pc_inc) state_d = FS_FETCH;
      FS_ERR:   state_d = FS_ERR;
      default:  state_d = FS_ERR;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    mem_req     = (state_q == FS_FETCH);
    fetch_state = state_q;
  end

  // Datapath next-state: PC, instruction capture, valid flag, fault and timeout counter.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      FS_IDLE: tmo_d = '0;
      FS_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      FS_HOLD: begin
        if (pc_inc) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          tmo_d   = '0;
        end
      end
      FS_ERR:  valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= {RESET_PC[ADDR_W-1:1], 1'b0};
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases plus randomized
// fetch/advance traffic against a transaction-level PC/instruction model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_inc;
  logic        en_pc_2;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic        inst_valid;
  logic [15:0] pc;
  logic        fetch_err;
  logic [1:0]  fetch_state;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: address expected for the current fetch, last captured word.
  logic [15:0] exp_pc;
  logic [15:0] exp_instr;

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000),
    .TIMEOUT  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_inc        (pc_inc),
    .en_pc_2       (en_pc_2),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .fetch_err     (fetch_err),
    .fetch_state   (fetch_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    pc_inc    = 1'b0;
    en_pc_2   = 1'b0;
    branch_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},    pc, 16'h0000);
    check({tag, "_instr"}, instruction, 16'h0000);
    check({tag, "_valid"}, inst_valid, 1'b0);
    check({tag, "_req"},   mem_req, 1'b0);
    check({tag, "_err"},   fetch_err, 1'b0);
    check({tag, "_state"}, fetch_state, 2'd0);
  endtask

  // Entered just after the edge into FETCH; withholds ack for lat cycles
  // (with stray control pulses that must be ignored), then acks with data.
  task automatic do_fetch(input int unsigned lat, input logic [15:0] data);
    for (int unsigned i = 0; i < lat; i++) begin
      check("fetch_req", mem_req, 1'b1);
      check("fetch_addr", mem_addr, exp_pc);
      mem_ack       = 1'b0;
      mem_rdata     = 16'($urandom);
      pc_inc        = 1'($urandom_range(0, 1));
      branch_en     = 1'($urandom_range(0, 1));
      en_pc_2       = 1'($urandom_range(0, 1));
      branch_target = 16'($urandom);
      tick();
    end
    check("fetch_req", mem_req, 1'b1);
    check("fetch_addr", mem_addr, exp_pc);
    check("fetch_err_pre", fetch_err, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = data;
    pc_inc    = 1'($urandom_range(0, 1));
    tick();
    mem_ack = 1'b0;
    clear_ctl();
    exp_instr = data;
    check("hold_valid", inst_valid, 1'b1);
    check("hold_instr", instruction, exp_instr);
    check("hold_pc", pc, exp_pc);
    check("hold_req", mem_req, 1'b0);
    check("hold_state", fetch_state, 2'd2);
    check("hold_err", fetch_err, 1'b0);
  endtask

  // HOLD cycles with branch/skip strobes but no pc_inc: nothing may move.
  task automatic hold_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pc_inc        = 1'b0;
      branch_en     = 1'($urandom_range(0, 1));
      en_pc_2       = 1'($urandom_range(0, 1));
      branch_target = 16'($urandom);
      mem_ack       = 1'($urandom_range(0, 1));
      tick();
      check("idle_pc", pc, exp_pc);
      check("idle_instr", instruction, exp_instr);
      check("idle_valid", inst_valid, 1'b1);
      check("idle_req", mem_req, 1'b0);
    end
    clear_ctl();
    mem_ack = 1'b0;
  endtask

  // pc_inc pulse in HOLD; model applies the architectural PC rule directly.
  task automatic advance(input logic br, input logic en2, input logic [15:0] tgt);
    pc_inc        = 1'b1;
    branch_en     = br;
    en_pc_2       = en2;
    branch_target = tgt;
    if (br)       exp_pc = tgt & 16'hFFFE;
    else if (en2) exp_pc = 16'((32'(exp_pc) + 32'd4) % 32'd65536);
    else          exp_pc = 16'((32'(exp_pc) + 32'd2) % 32'd65536);
    tick();
    clear_ctl();
    check("adv_valid", inst_valid, 1'b0);
    check("adv_req", mem_req, 1'b1);
    check("adv_addr", mem_addr, exp_pc);
    check("adv_state", fetch_state, 2'd1);
  endtask

  initial begin
    rst           = 1'b1;
    clear_ctl();
    branch_target = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    exp_pc        = 16'h0000;
    exp_instr     = 16'h0000;

    #2;
    check_reset_vals("rst");

    // Reset release with ack tied high and rdata = 0x1234.
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    check_reset_vals("rst_ack");
    rst = 1'b0;
    tick();
    check("rel_state", fetch_state, 2'd1);
    do_fetch(0, 16'h1234);

    // Sequential steps, skip, branch priority with bit-0 clear.
    advance(1'b0, 1'b0, 16'h0000); do_fetch(0, 16'hA001);
    advance(1'b0, 1'b0, 16'h0000); do_fetch(1, 16'hA002);
    advance(1'b0, 1'b0, 16'h0000); do_fetch(0, 16'hA003);
    check("seq_pc6", pc, 16'h0006);
    advance(1'b0, 1'b1, 16'h0000); do_fetch(0, 16'hA004);
    check("skip_pcA", pc, 16'h000A);
    hold_idle(3);
    advance(1'b1, 1'b1, 16'h0101); do_fetch(2, 16'hA005);
    check("br_pc100", pc, 16'h0100);

    // Wrap-around cases.
    advance(1'b1, 1'b0, 16'hFFFE); do_fetch(0, 16'hB001);
    advance(1'b0, 1'b0, 16'h0000); do_fetch(3, 16'hB002);
    check("wrap_step", pc, 16'h0000);
    advance(1'b1, 1'b0, 16'hFFFE); do_fetch(0, 16'hB003);
    advance(1'b0, 1'b1, 16'h0000); do_fetch(0, 16'hB004);
    check("wrap_skip2", pc, 16'h0002);
    advance(1'b1, 1'b0, 16'hFFFC); do_fetch(0, 16'hB005);
    advance(1'b0, 1'b1, 16'h0000); do_fetch(0, 16'hB006);
    check("wrap_skip0", pc, 16'h0000);

    // Ack on the last permitted cycle is a normal capture.
    advance(1'b0, 1'b0, 16'h0000); do_fetch(15, 16'hC0DE);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int unsigned mode;
      hold_idle($urandom_range(0, 2));
      mode = $urandom_range(0, 3);
      advance(mode == 3, (mode == 2) || (mode == 3 && $urandom_range(0, 1) == 1),
              16'($urandom));
      do_fetch($urandom_range(0, 15), 16'($urandom));
    end

    // Timeout: 16 ack-less FETCH cycles enter ERR.
    advance(1'b0, 1'b0, 16'h0000);
    mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("tmo_req", mem_req, 1'b1);
      check("tmo_noerr", fetch_err, 1'b0);
      tick();
    end
    check("err_state", fetch_state, 2'd3);
    check("err_flag", fetch_err, 1'b1);
    check("err_req", mem_req, 1'b0);
    check("err_valid", inst_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pc_inc    = 1'($urandom_range(0, 1));
      branch_en = 1'($urandom_range(0, 1));
      en_pc_2   = 1'($urandom_range(0, 1));
      mem_ack   = 1'($urandom_range(0, 1));
      tick();
      check("err_stuck_state", fetch_state, 2'd3);
      check("err_stuck_flag", fetch_err, 1'b1);
      check("err_stuck_req", mem_req, 1'b0);
      check("err_stuck_pc", pc, exp_pc);
    end
    clear_ctl();
    mem_ack = 1'b0;

    // Asynchronous reset out of ERR.
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("arst_err");
    exp_pc = 16'h0000;
    tick();
    rst = 1'b0;
    tick();
    check("rel2_state", fetch_state, 2'd1);
    do_fetch(1, 16'h5A5A);

    // Reset while a request is outstanding, with a late ack under reset.
    advance(1'b0, 1'b1, 16'h0000);
    tick();
    tick();
    check("late_req", mem_req, 1'b1);
    #2;
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    check_reset_vals("arst_req");
    tick();
    check_reset_vals("arst_ack");
    mem_ack = 1'b0;
    rst     = 1'b0;
    exp_pc  = 16'h0000;
    tick();
    check("rel3_state", fetch_state, 2'd1);
    check("rel3_instr", instruction, 16'h0000);
    do_fetch(2, 16'h7E57);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
